// File: rtl/memory_access_unit.sv
// MIPS memory stage: alignment check, one split-handshake data-bus request per
// instruction, then load alignment/extension and handoff to writeback.

package mau_pkg;
    typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;
    typedef enum logic {UNSIGNED = 1'b0, SIGNED = 1'b1} sig_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        sig_t        sig;
        msize_t      msize;
        logic [31:0] data;
    } memory_args_t;
endpackage

module memory_access_unit
    import mau_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  memory_args_t in_args,
    input  logic [31:0]  in_addr,
    output logic         dreq_valid,
    output logic [31:0]  dreq_addr,
    output logic [1:0]   dreq_size,
    output logic [3:0]   dreq_strobe,
    output logic [31:0]  dreq_data,
    input  logic         dresp_addr_ok,
    input  logic         dresp_data_ok,
    input  logic [31:0]  dresp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_adel,
    output logic         out_ades
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        killed;
    logic        write_q;
    sig_t        sig_q;
    msize_t      msize_q;
    logic [1:0]  offset_q;
    logic        accept;
    logic        misalign;
    logic        complete;
    logic        drop;

    function automatic logic is_misaligned(input msize_t m, input logic [1:0] o);
        return (m == MSIZE2 && o[0]) || (m == MSIZE4 && o != 2'b00);
    endfunction

    function automatic logic [3:0] store_strobe(input msize_t m, input logic [1:0] o);
        case (m)
            MSIZE1:  return 4'b0001 << o;
            MSIZE2:  return 4'b0011 << o;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input msize_t m, input logic [31:0] d);
        case (m)
            MSIZE1:  return {4{d[7:0]}};
            MSIZE2:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [1:0] o,
                                               input msize_t m, input sig_t s);
        logic [31:0] sh;
        sh = raw >> {o, 3'b000};
        case (m)
            MSIZE1:  return (s == SIGNED) ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            MSIZE2:  return (s == SIGNED) ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // A flush in IDLE also swallows any in_valid presented that cycle.
    assign accept   = in_valid && (state == IDLE) && !flush;
    assign misalign = is_misaligned(in_args.msize, in_addr[1:0]);
    assign complete = ((state == REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state == WAIT) && dresp_data_ok);
    assign drop     = killed || flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (!in_args.valid || misalign) ? DONE : REQ;
                end
            end
            REQ: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        next_state = drop ? IDLE : DONE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    next_state = drop ? IDLE : DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        dreq_valid = (state == REQ);
        out_valid  = (state == DONE);
    end

    // A killed transaction still runs to completion on the bus; it just never reaches DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            killed <= 1'b0;
        end else if (next_state == IDLE) begin
            killed <= 1'b0;
        end else if (flush && (state == REQ || state == WAIT)) begin
            killed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q     <= 1'b0;
            sig_q       <= UNSIGNED;
            msize_q     <= MSIZE1;
            offset_q    <= 2'b00;
            dreq_addr   <= 32'b0;
            dreq_size   <= 2'b0;
            dreq_strobe <= 4'b0;
            dreq_data   <= 32'b0;
            out_data    <= 32'b0;
            out_adel    <= 1'b0;
            out_ades    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= in_args.write;
                sig_q    <= in_args.sig;
                msize_q  <= in_args.msize;
                offset_q <= in_addr[1:0];
                out_data <= 32'b0;
                out_adel <= in_args.valid && misalign && !in_args.write;
                out_ades <= in_args.valid && misalign && in_args.write;
                if (in_args.valid && !misalign) begin
                    dreq_addr   <= in_addr;
                    dreq_size   <= in_args.msize;
                    dreq_strobe <= in_args.write ? store_strobe(in_args.msize, in_addr[1:0]) : 4'b0;
                    dreq_data   <= in_args.write ? store_data(in_args.msize, in_args.data) : 32'b0;
                end
            end
            if (complete && !write_q) begin
                out_data <= load_value(dresp_data, offset_q, msize_q, sig_q);
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized and directed bench for memory_access_unit with a byte-level
// reference model of store encoding, load extension and alignment errors.

module tb_memory_access_unit;
    import mau_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    memory_args_t in_args;
    logic [31:0]  in_addr;
    logic         dreq_valid;
    logic [31:0]  dreq_addr;
    logic [1:0]   dreq_size;
    logic [3:0]   dreq_strobe;
    logic [31:0]  dreq_data;
    logic         dresp_addr_ok;
    logic         dresp_data_ok;
    logic [31:0]  dresp_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_adel;
    logic         out_ades;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_args(in_args), .in_addr(in_addr),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_adel(out_adel), .out_ades(out_ades)
    );

    typedef struct {
        bit          bus;
        logic        adel;
        logic        ades;
        logic [31:0] odata;
        logic [3:0]  strobe;
        logic [31:0] ddata;
        logic [1:0]  size;
    } exp_t;

    typedef struct {
        int          req_cycles;
        bit          dreq_stable;
        logic [31:0] dreq_addr;
        logic [31:0] dreq_data;
        logic [1:0]  dreq_size;
        logic [3:0]  dreq_strobe;
        int          lat;
        bit          timeout;
        logic [31:0] odata;
        logic        adel;
        logic        ades;
        bit          ready_at_accept;
        bit          out_stable;
        bit          ready_after;
        bit          saw_out;
    } obs_t;

    // Byte-lane view of the access: which lanes it touches and how bytes map.
    function automatic exp_t model(input memory_args_t a, input logic [31:0] addr,
                                   input logic [31:0] rdata);
        exp_t   e;
        int     nb;
        int     o;
        longint v;
        e.bus = 0; e.adel = 0; e.ades = 0; e.odata = '0;
        e.strobe = '0; e.ddata = '0; e.size = '0;
        nb = (a.msize == MSIZE1) ? 1 : (a.msize == MSIZE2) ? 2 : 4;
        o  = int'(addr[1:0]);
        if (!a.valid) return e;
        if (o % nb != 0) begin
            e.adel = !a.write;
            e.ades = a.write;
            return e;
        end
        e.bus  = 1;
        e.size = a.msize;
        if (a.write) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= o && i < o + nb) e.strobe[i] = 1'b1;
                e.ddata[8*i +: 8] = a.data[8*(i % nb) +: 8];
            end
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v += longint'(rdata[8*(o+k) +: 8]) << (8*k);
            if (a.sig == SIGNED && v >= (longint'(1) << (8*nb - 1))) v -= (longint'(1) << (8*nb));
            e.odata = v[31:0];
        end
        return e;
    endfunction

    function automatic memory_args_t mk(input bit valid, input bit write, input sig_t s,
                                        input msize_t m, input logic [31:0] d);
        memory_args_t a;
        a.valid = valid; a.write = write; a.sig = s; a.msize = m; a.data = d;
        return a;
    endfunction

    // Drives one instruction from a negedge and plays the bus slave; ends on a negedge.
    task automatic do_op(input memory_args_t a, input logic [31:0] addr, input int aw,
                         input int dw, input logic [31:0] rdata, input bit bus,
                         input int hold, input bit do_flush, output obs_t o);
        int n;
        int w;
        o.req_cycles = 0; o.dreq_stable = 1; o.dreq_addr = '0; o.dreq_data = '0;
        o.dreq_size = '0; o.dreq_strobe = '0; o.lat = -1; o.timeout = 0; o.odata = '0;
        o.adel = 0; o.ades = 0; o.out_stable = 1; o.ready_after = 0; o.saw_out = 0;
        o.ready_at_accept = in_ready;
        in_valid = 1'b1; in_args = a; in_addr = addr;
        @(negedge clk); in_valid = 1'b0; n = 1;
        if (bus) begin
            for (int r = 0; r <= aw; r++) begin
                if (dreq_valid) o.req_cycles++;
                if (out_valid) o.saw_out = 1;
                if (r == 0) begin
                    o.dreq_addr = dreq_addr; o.dreq_size = dreq_size;
                    o.dreq_strobe = dreq_strobe; o.dreq_data = dreq_data;
                end else if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !==
                             {o.dreq_addr, o.dreq_size, o.dreq_strobe, o.dreq_data}) begin
                    o.dreq_stable = 0;
                end
                if (r == aw) begin
                    dresp_addr_ok = 1'b1;
                    if (dw == 0) begin dresp_data_ok = 1'b1; dresp_data = rdata; end
                end
                @(negedge clk); n++; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
            end
            for (int d = 1; d <= dw; d++) begin
                if (out_valid) o.saw_out = 1;
                if (d == dw) begin dresp_data_ok = 1'b1; dresp_data = rdata; end
                if (d == 1 && do_flush) flush = 1'b1;
                @(negedge clk); n++; dresp_data_ok = 1'b0; flush = 1'b0;
            end
            if (do_flush) begin
                o.ready_after = in_ready;
                if (out_valid) o.saw_out = 1;
                @(negedge clk);
                if (out_valid) o.saw_out = 1;
                return;
            end
        end
        w = 0;
        while (!out_valid && w < 20) begin
            if (dreq_valid) o.req_cycles++;
            @(negedge clk); n++; w++;
        end
        if (!out_valid) begin o.timeout = 1; return; end
        o.lat = n; o.odata = out_data; o.adel = out_adel; o.ades = out_ades;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_data !== o.odata ||
                out_adel !== o.adel || out_ades !== o.ades) o.out_stable = 0;
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        o.ready_after = in_ready;
    endtask

    task automatic test_reset();
        checks++; if ({in_ready, dreq_valid, out_valid} !== 3'b100) begin errors++;
            $display("[TB] FAIL reset_handshake got %b want 100", {in_ready, dreq_valid, out_valid}); end
        checks++; if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !== 70'b0) begin errors++;
            $display("[TB] FAIL reset_dreq got %h/%h/%h/%h want 0", dreq_addr, dreq_size, dreq_strobe, dreq_data); end
        checks++; if ({out_data, out_adel, out_ades} !== 34'b0) begin errors++;
            $display("[TB] FAIL reset_out got %h %b %b want 0", out_data, out_adel, out_ades); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        do_op(mk(1, 0, SIGNED, MSIZE1, 32'h0), 32'h0000_1003, 0, 0, 32'h80FF_0000, 1, 0, 0, o);
        checks++; if (o.timeout !== 0 || o.lat !== 2) begin errors++;
            $display("[TB] FAIL lb_latency got %0d (timeout %0d) want 2", o.lat, o.timeout); end
        checks++; if (o.odata !== 32'hFFFF_FF80) begin errors++;
            $display("[TB] FAIL lb_data got %h want ffffff80", o.odata); end
        checks++; if (o.req_cycles !== 1 || o.dreq_strobe !== 4'b0000) begin errors++;
            $display("[TB] FAIL lb_req got %0d cycles strobe %b want 1 cycle strobe 0000", o.req_cycles, o.dreq_strobe); end
        do_op(mk(1, 0, UNSIGNED, MSIZE1, 32'h0), 32'h0000_1003, 0, 0, 32'h80FF_0000, 1, 0, 0, o);
        checks++; if (o.odata !== 32'h0000_0080) begin errors++;
            $display("[TB] FAIL lbu_data got %h want 00000080", o.odata); end
    endtask

    task automatic test_store_half();
        obs_t o;
        do_op(mk(1, 1, UNSIGNED, MSIZE2, 32'h1234_ABCD), 32'h0000_2002, 3, 2, 32'hDEAD_BEEF, 1, 0, 0, o);
        checks++; if (o.req_cycles !== 4 || o.dreq_stable !== 1) begin errors++;
            $display("[TB] FAIL sh_hold got %0d cycles stable %0d want 4 stable 1", o.req_cycles, o.dreq_stable); end
        checks++; if (o.dreq_strobe !== 4'b1100 || o.dreq_size !== 2'd1) begin errors++;
            $display("[TB] FAIL sh_strobe got %b size %0d want 1100 size 1", o.dreq_strobe, o.dreq_size); end
        checks++; if (o.dreq_data !== 32'hABCD_ABCD || o.dreq_addr !== 32'h0000_2002) begin errors++;
            $display("[TB] FAIL sh_data got %h @%h want abcdabcd @00002002", o.dreq_data, o.dreq_addr); end
        checks++; if (o.timeout !== 0 || o.odata !== 32'h0 || o.lat !== 7) begin errors++;
            $display("[TB] FAIL sh_result got %h lat %0d want 0 lat 7", o.odata, o.lat); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_op(mk(1, 0, SIGNED, MSIZE4, 32'h0), 32'h0000_3001, 0, 0, 32'h0, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || {o.adel, o.ades} !== 2'b10 || o.req_cycles !== 0) begin errors++;
            $display("[TB] FAIL lw_adel got lat %0d adel/ades %b%b req %0d want 1 10 0", o.lat, o.adel, o.ades, o.req_cycles); end
        do_op(mk(1, 1, UNSIGNED, MSIZE4, 32'h5555_AAAA), 32'h0000_3002, 0, 0, 32'h0, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || {o.adel, o.ades} !== 2'b01 || o.req_cycles !== 0) begin errors++;
            $display("[TB] FAIL sw_ades got lat %0d adel/ades %b%b req %0d want 1 01 0", o.lat, o.adel, o.ades, o.req_cycles); end
        do_op(mk(0, 1, SIGNED, MSIZE4, 32'hFFFF_FFFF), 32'h0000_3003, 0, 0, 32'h0, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || {o.odata, o.adel, o.ades} !== 34'b0 || o.req_cycles !== 0) begin errors++;
            $display("[TB] FAIL nonmem got lat %0d data %h err %b%b want 1 0 00", o.lat, o.odata, o.adel, o.ades); end
    endtask

    task automatic test_flush_wait();
        obs_t o;
        do_op(mk(1, 0, SIGNED, MSIZE2, 32'h0), 32'h0000_4002, 1, 3, 32'h8001_7FFF, 1, 0, 1, o);
        checks++; if (o.req_cycles !== 2) begin errors++;
            $display("[TB] FAIL flush_req got %0d want 2", o.req_cycles); end
        checks++; if (o.saw_out !== 0) begin errors++;
            $display("[TB] FAIL flush_out_valid got %0d want 0", o.saw_out); end
        checks++; if (o.ready_after !== 1) begin errors++;
            $display("[TB] FAIL flush_in_ready got %0d want 1", o.ready_after); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        logic [31:0] rd;
        rd = $urandom;
        e = model(mk(1, 0, UNSIGNED, MSIZE4, 32'h0), 32'h0000_5000, rd);
        do_op(mk(1, 0, UNSIGNED, MSIZE4, 32'h0), 32'h0000_5000, 0, 1, rd, 1, 5, 0, o);
        checks++; if (o.out_stable !== 1 || o.timeout !== 0) begin errors++;
            $display("[TB] FAIL bp_stable got %0d want 1", o.out_stable); end
        checks++; if (o.odata !== e.odata || o.ready_after !== 1) begin errors++;
            $display("[TB] FAIL bp_data got %h ready %0d want %h ready 1", o.odata, o.ready_after, e.odata); end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        do_op(mk(1, 0, UNSIGNED, MSIZE1, 32'h0), 32'h0000_6001, 0, 0, 32'h0000_C300, 1, 0, 0, o1);
        do_op(mk(1, 1, UNSIGNED, MSIZE1, 32'h0000_005A), 32'h0000_6003, 0, 0, 32'h0, 1, 0, 0, o2);
        checks++; if (o1.lat !== 2 || o2.lat !== 2 || o2.ready_at_accept !== 1) begin errors++;
            $display("[TB] FAIL b2b_latency got %0d/%0d ready %0d want 2/2 ready 1", o1.lat, o2.lat, o2.ready_at_accept); end
        checks++; if (o1.odata !== 32'h0000_00C3 || o2.dreq_strobe !== 4'b1000 || o2.dreq_data !== 32'h5A5A_5A5A) begin errors++;
            $display("[TB] FAIL b2b_data got %h %b %h want 000000c3 1000 5a5a5a5a", o1.odata, o2.dreq_strobe, o2.dreq_data); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_args = mk(1, 1, UNSIGNED, MSIZE4, 32'h1111_2222); in_addr = 32'h0000_7004;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (dreq_valid !== 1 || dreq_addr !== 32'h0000_7004) begin errors++;
            $display("[TB] FAIL rst_mid_req got %0d %h want 1 00007004", dreq_valid, dreq_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({in_ready, dreq_valid, out_valid, dreq_addr, dreq_strobe, dreq_data} !== {3'b100, 68'b0}) begin errors++;
            $display("[TB] FAIL rst_mid_outputs got %b%b%b %h %b %h want 100 0", in_ready, dreq_valid, out_valid, dreq_addr, dreq_strobe, dreq_data); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t         o;
        exp_t         e;
        memory_args_t a;
        logic [31:0]  addr;
        logic [31:0]  rd;
        int           aw;
        int           dw;
        for (int i = 0; i < 40; i++) begin
            a = mk($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                   sig_t'($urandom_range(0, 1)), msize_t'($urandom_range(0, 2)), $urandom);
            addr = $urandom; rd = $urandom;
            aw = $urandom_range(0, 3); dw = $urandom_range(0, 2);
            e = model(a, addr, rd);
            do_op(a, addr, aw, dw, rd, e.bus, $urandom_range(0, 2), 0, o);
            checks++; if (o.timeout !== 0 || o.lat !== (e.bus ? aw + dw + 2 : 1)) begin errors++;
                $display("[TB] FAIL rnd%0d_latency got %0d want %0d", i, o.lat, e.bus ? aw + dw + 2 : 1); end
            checks++; if ({o.odata, o.adel, o.ades} !== {e.odata, e.adel, e.ades}) begin errors++;
                $display("[TB] FAIL rnd%0d_result got %h %b%b want %h %b%b", i, o.odata, o.adel, o.ades, e.odata, e.adel, e.ades); end
            checks++; if (o.req_cycles !== (e.bus ? aw + 1 : 0) || o.out_stable !== 1 || o.ready_after !== 1) begin errors++;
                $display("[TB] FAIL rnd%0d_handshake got req %0d stable %0d ready %0d", i, o.req_cycles, o.out_stable, o.ready_after); end
            if (e.bus) begin
                checks++; if (o.dreq_addr !== addr || o.dreq_size !== e.size || o.dreq_strobe !== e.strobe || o.dreq_stable !== 1) begin errors++;
                    $display("[TB] FAIL rnd%0d_dreq got %h %0d %b want %h %0d %b", i, o.dreq_addr, o.dreq_size, o.dreq_strobe, addr, e.size, e.strobe); end
                if (a.write) begin
                    checks++; if (o.dreq_data !== e.ddata) begin errors++;
                        $display("[TB] FAIL rnd%0d_wdata got %h want %h", i, o.dreq_data, e.ddata); end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_args = '0; in_addr = '0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_flush_wait();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the MIPS pipeline. Consumes the decoded `memory_args_t` bundle plus the effective address from execute, checks alignment, and issues one request on the data bus (`dreq`/`dresp`, split address/data handshake). It then aligns and extends load data and hands the result to writeback through a valid/ready handshake. Non-memory instructions pass through with no bus activity.

## Interface
Parameters:
- none (widths fixed by `common.svh`: word 32 bits)

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  kill in-flight instruction (see Operation)
- `in_valid`  in  1  execute stage presents an instruction
- `in_ready`  out  1  unit can accept (`state == IDLE`)
- `in_args`  in  memory_args_t  fields: `valid`, `write`, `sig`, `msize`, `data` (store data)
- `in_addr`  in  32  effective address
- `dreq_valid`  out  1  bus request valid
- `dreq_addr`  out  32  unaligned effective address, passed unmodified
- `dreq_size`  out  2  0=1B, 1=2B, 2=4B
- `dreq_strobe`  out  4  byte write enables; 0 for loads
- `dreq_data`  out  32  lane-replicated store data
- `dresp_addr_ok`  in  1  request accepted
- `dresp_data_ok`  in  1  transaction complete (loads and stores)
- `dresp_data`  in  32  raw load word
- `out_valid`  out  1  result ready for writeback
- `out_ready`  in  1  writeback accepts
- `out_data`  out  32  extended load value; 0 for stores and non-memory ops
- `out_adel`  out  1  load address error
- `out_ades`  out  1  store address error

## Operation
- Four states: IDLE, REQ, WAIT, DONE.
- Accept:
  - On `in_valid && in_ready`, latch `in_args` and `in_addr`.
  - If `!in_args.valid`: go to DONE with all results 0.
  - Misaligned access (MSIZE2 with `addr[0]`, MSIZE4 with `addr[1:0] != 0`): go to DONE, set `out_adel` (load) or `out_ades` (store); no bus request.
  - Otherwise go to REQ.
- REQ:
  - `dreq_valid = 1`. All `dreq_*` fields are stable until `dresp_addr_ok`.
  - On `addr_ok`: go to WAIT. If `data_ok` is also high in the same cycle, go directly to DONE.
- WAIT: on `data_ok`, capture the result and go to DONE.
- DONE: `out_valid = 1`, outputs held stable; on `out_ready`, go to IDLE.
- Store encoding, with `o = addr[1:0]`:
  - MSIZE1: strobe `4'b0001 << o`, data `{4{data[7:0]}}`.
  - MSIZE2: strobe `4'b0011 << o`, data `{2{data[15:0]}}`.
  - MSIZE4: strobe `4'b1111`, data as-is.
- Load extraction:
  - `sh = dresp_data >> (8*o)`.
  - Take the low 8 or 16 bits (or the full word) of `sh`.
  - Sign-extend if `sig == SIGNED`, else zero-extend.
- Flush:
  - In IDLE: no effect.
  - In DONE: drop the result and go to IDLE; `out_valid` falls next cycle.
  - In REQ/WAIT: set an internal `killed` bit. The bus request is never withdrawn; the transaction completes, then the unit returns to IDLE without asserting `out_valid`.
  - Upstream never flushes a store once it is accepted.
- Simultaneous flush and accept: impossible (`in_ready` only in IDLE); flush in IDLE ignores `in_valid` that cycle.

## Timing
- Reset values: state IDLE, `in_ready = 1`, `dreq_valid = 0`, `dreq_*` = 0, `out_valid = 0`, `out_data = 0`, `out_adel = out_ades = 0`, `killed = 0`.
- `in_ready` and `out_valid` decode combinationally from the state register. All `dreq_*` and `out_*` data come from registers; no combinational path from `dresp_*` to any output.
- Best-case bus op (addr_ok and data_ok in the first REQ cycle):
  - accept in cycle 0;
  - REQ in cycle 1;
  - DONE/`out_valid` in cycle 2.
- Error or non-memory op: accept in cycle 0, `out_valid` in cycle 1.
- Throughput: one instruction per 2 cycles at best (DONE→IDLE→accept).
- Reset mid-transaction forces IDLE immediately; bus-side cleanup is not this block's responsibility.

## Test plan
- LB at addr 0x...3, `dresp_data = 0x80FF_0000`, addr_ok and data_ok in the same cycle → `out_data = 0xFFFF_FF80`, `out_valid` 2 cycles after accept. LBU on the same data → `0x0000_0080`.
- SH `data = 0x1234_ABCD` at addr 0x...2, addr_ok delayed 3 cycles → `dreq` held stable for 4 cycles; `strobe = 4'b1100`, `dreq_data = 0xABCD_ABCD`, `size = 1`; `out_data = 0` after data_ok.
- LW at addr 0x...1 → `out_adel = 1` the cycle after accept, `dreq_valid` never asserts. SW at 0x...2 → `out_ades = 1`.
- Flush asserted in WAIT of an LH → `dreq` completes normally, `out_valid` stays 0, and `in_ready = 1` the cycle after data_ok.
- `out_ready` held low 5 cycles in DONE → `out_valid`, `out_data` and `in_ready = 0` stay stable; `reset` pulsed in REQ → all outputs return to reset values that cycle.
